bus_cycle_ctrl: RTL and testbench

Sequences the 8085 external bus, one machine cycle per request, one T-state per phi1 clock. Generates ALE, RDn, WRn, IOMn, S1 and S0, and drives the multiplexed AD bus. Inserts wait states from ready and arbitrates the bus against external hold/hlda. It sits between the decoding sequencer, which issues cycle requests, and the pin drivers.

---
 rtl/bus_cycle_ctrl_if.sv | 45 ++++
 rtl/bus_cycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/bus_cycle_ctrl_if.sv
// Request-side and 8085 pin-side signals of the bus cycle controller.
// slave is the controller's view; master is the sequencer/pin-driver view.
interface bus_cycle_ctrl_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic              cyc_req;
  logic [2:0]        cyc_type;
  logic              cyc_long;
  logic [ADDR_W-1:0] cyc_addr;
  logic [DATA_W-1:0] cyc_wdata;
  logic              cyc_ack;
  logic              cyc_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              bus_err;
  logic              busy;
  logic [DATA_W-1:0] ad_in;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic [ADDR_W-9:0] a_hi;
  logic              ctrl_oe;
  logic              ALE;
  logic              RDn;
  logic              WRn;
  logic              IOMn;
  logic              S1;
  logic              S0;
  logic              ready;
  logic              hold;
  logic              hlda;
  logic [3:0]        t_state;

  modport slave (
    input  cyc_req, cyc_type, cyc_long, cyc_addr, cyc_wdata, ad_in, ready, hold,
    output cyc_ack, cyc_done, rd_data, rd_valid, bus_err, busy, ad_out, ad_oe,
           a_hi, ctrl_oe, ALE, RDn, WRn, IOMn, S1, S0, hlda, t_state
  );

  modport master (
    output cyc_req, cyc_type, cyc_long, cyc_addr, cyc_wdata, ad_in, ready, hold,
    input  cyc_ack, cyc_done, rd_data, rd_valid, bus_err, busy, ad_out, ad_oe,
           a_hi, ctrl_oe, ALE, RDn, WRn, IOMn, S1, S0, hlda, t_state
  );
endinterface

// File: rtl/bus_cycle_ctrl.sv
// 8085 external bus sequencer: one machine cycle per request, one T-state per
// phi1 clock, with ready wait states and hold/hlda arbitration.
module bus_cycle_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 0
) (
  input  logic phi1,
  input  logic reset,
  bus_cycle_ctrl_if.slave bus
);

  localparam int unsigned W_CNT = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [3:0] {
    TIDLE = 4'd0, T1 = 4'd1, T2 = 4'd2, TW = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, THOLD = 4'd8
  } tstate_e;

  typedef enum logic [2:0] {
    CYC_OPF = 3'd0, CYC_MRD = 3'd1, CYC_MWR = 3'd2, CYC_IORD = 3'd3, CYC_IOWR = 3'd4
  } cyc_e;

  function automatic logic [2:0] status_of(input cyc_e t);
    case (t)
      CYC_OPF:  status_of = 3'b011;
      CYC_MRD:  status_of = 3'b010;
      CYC_MWR:  status_of = 3'b001;
      CYC_IORD: status_of = 3'b110;
      CYC_IOWR: status_of = 3'b101;
      default:  status_of = 3'b000;
    endcase
  endfunction

  tstate_e           r_state, w_state;
  logic              r_pend, w_pend;
  logic              r_hold_go, w_hold_go;
  cyc_e              r_p_type, w_p_type;
  logic              r_p_long, w_p_long;
  logic [ADDR_W-1:0] r_p_addr, w_p_addr;
  logic [DATA_W-1:0] r_p_wdata, w_p_wdata;
  cyc_e              r_type, w_type;
  logic              r_long, w_long;
  logic [DATA_W-1:0] r_wdata, w_wdata;
  logic [W_CNT-1:0]  r_wcnt, w_wcnt;
  logic              r_err, w_err;

  logic              r_ack, w_ack, r_done, w_done, r_rdv, w_rdv, r_berr, w_berr;
  logic              r_busy, w_busy, r_ale, w_ale, r_rdn, w_rdn, r_wrn, w_wrn;
  logic              r_ad_oe, w_ad_oe, r_ctrl_oe, w_ctrl_oe, r_hlda, w_hlda;
  logic [2:0]        r_stat, w_stat;
  logic [DATA_W-1:0] r_ad_out, w_ad_out, r_rd_data, w_rd_data;
  logic [ADDR_W-9:0] r_a_hi, w_a_hi;

  logic w_fin_exit, w_fin_entry, w_accept, w_is_rd, w_timeout;

  always_comb begin
    w_state   = r_state;   w_pend    = r_pend;    w_hold_go = r_hold_go;
    w_p_type  = r_p_type;  w_p_long  = r_p_long;  w_p_addr  = r_p_addr;
    w_p_wdata = r_p_wdata; w_type    = r_type;    w_long    = r_long;
    w_wdata   = r_wdata;   w_wcnt    = r_wcnt;    w_err     = r_err;
    w_ack = 1'b0; w_done = 1'b0; w_rdv = 1'b0; w_berr = 1'b0;
    w_ale = r_ale; w_rdn = r_rdn; w_wrn = r_wrn; w_ad_oe = r_ad_oe;
    w_ctrl_oe = r_ctrl_oe; w_hlda = r_hlda; w_stat = r_stat;
    w_ad_out = r_ad_out; w_a_hi = r_a_hi; w_rd_data = r_rd_data;
    w_fin_exit = 1'b0; w_fin_entry = 1'b0; w_accept = 1'b0;
    w_is_rd    = (r_type != CYC_MWR) && (r_type != CYC_IOWR);
    w_timeout  = (MAX_WAIT > 0) && (r_wcnt == W_CNT'(MAX_WAIT));

    unique case (r_state)
      TIDLE: begin
        if (r_pend)        w_state = T1;
        else if (bus.hold) w_state = THOLD;
        else               w_accept = 1'b1;
      end
      T1: w_state = T2;
      T2, TW: begin
        if (bus.ready) begin
          w_state = T3;
        end else if (r_state == TW && w_timeout) begin
          w_state = T3;
          w_err   = 1'b1;
        end else begin
          w_state = TW;
          w_wcnt  = r_wcnt + W_CNT'(1);
        end
      end
      T3: begin
        if (w_is_rd) begin
          w_rdv     = 1'b1;
          w_rd_data = bus.ad_in;
        end
        if (r_type == CYC_OPF) w_state = T4;
        else                   w_fin_exit = 1'b1;
      end
      T4: begin
        if (r_long) w_state = T5;
        else        w_fin_exit = 1'b1;
      end
      T5: w_state = T6;
      T6: w_fin_exit = 1'b1;
      THOLD: begin
        if (!bus.hold) w_state = TIDLE;
      end
      default: w_state = TIDLE;
    endcase

    if (w_fin_exit) begin
      w_hold_go = 1'b0;
      w_state   = r_pend ? T1 : (r_hold_go ? THOLD : TIDLE);
    end

    // The acceptance decision is registered on the edge entering the final
    // T-state, so cyc_ack is visible during that state and T1 follows directly.
    w_fin_entry = (w_state == T3 && r_type != CYC_OPF) ||
                  (w_state == T4 && !r_long) || (w_state == T6);
    if (w_fin_entry) begin
      w_done = 1'b1;
      w_berr = w_err;
      if (bus.hold) w_hold_go = 1'b1;
      else          w_accept  = 1'b1;
    end

    if (w_accept && bus.cyc_req && bus.cyc_type <= 3'd4) begin
      w_ack     = 1'b1;
      w_pend    = 1'b1;
      w_p_type  = cyc_e'(bus.cyc_type);
      w_p_long  = bus.cyc_long;
      w_p_addr  = bus.cyc_addr;
      w_p_wdata = bus.cyc_wdata;
    end

    unique case (w_state)
      TIDLE: begin
        w_ale = 1'b0; w_rdn = 1'b1; w_wrn = 1'b1; w_ad_oe = 1'b0;
        w_ctrl_oe = 1'b1; w_hlda = 1'b0; w_stat = 3'b000;
      end
      T1: begin
        w_pend  = 1'b0;
        w_type  = r_p_type; w_long = r_p_long; w_wdata = r_p_wdata;
        w_wcnt  = '0;       w_err  = 1'b0;
        w_ale   = 1'b1; w_rdn = 1'b1; w_wrn = 1'b1; w_ad_oe = 1'b1;
        w_ad_out = r_p_addr[7:0];
        w_a_hi   = r_p_addr[ADDR_W-1:8];
        w_stat   = status_of(r_p_type);
      end
      T2: begin
        w_ale = 1'b0;
        if (w_is_rd) begin
          w_rdn = 1'b0; w_ad_oe = 1'b0;
        end else begin
          w_wrn = 1'b0; w_ad_out = r_wdata; w_ad_oe = 1'b1;
        end
      end
      TW, T3: ;
      T4, T5, T6: begin
        w_rdn = 1'b1; w_wrn = 1'b1; w_ad_oe = 1'b0;
      end
      THOLD: begin
        w_hlda = 1'b1; w_ctrl_oe = 1'b0; w_ad_oe = 1'b0; w_ale = 1'b0;
        w_rdn = 1'b1; w_wrn = 1'b1;
      end
      default: ;
    endcase

    w_busy = (w_state != TIDLE) && (w_state != THOLD);
  end

  always_ff @(posedge phi1) begin
    if (reset) begin
      r_state <= TIDLE; r_pend <= 1'b0; r_hold_go <= 1'b0;
      r_p_type <= CYC_OPF; r_p_long <= 1'b0; r_p_addr <= '0; r_p_wdata <= '0;
      r_type <= CYC_OPF; r_long <= 1'b0; r_wdata <= '0; r_wcnt <= '0; r_err <= 1'b0;
      r_ack <= 1'b0; r_done <= 1'b0; r_rdv <= 1'b0; r_berr <= 1'b0; r_busy <= 1'b0;
      r_ale <= 1'b0; r_rdn <= 1'b1; r_wrn <= 1'b1; r_ad_oe <= 1'b0;
      r_ctrl_oe <= 1'b1; r_hlda <= 1'b0; r_stat <= 3'b000;
      r_ad_out <= '0; r_a_hi <= '0; r_rd_data <= '0;
    end else begin
      r_state <= w_state; r_pend <= w_pend; r_hold_go <= w_hold_go;
      r_p_type <= w_p_type; r_p_long <= w_p_long; r_p_addr <= w_p_addr;
      r_p_wdata <= w_p_wdata; r_type <= w_type; r_long <= w_long;
      r_wdata <= w_wdata; r_wcnt <= w_wcnt; r_err <= w_err;
      r_ack <= w_ack; r_done <= w_done; r_rdv <= w_rdv; r_berr <= w_berr;
      r_busy <= w_busy; r_ale <= w_ale; r_rdn <= w_rdn; r_wrn <= w_wrn;
      r_ad_oe <= w_ad_oe; r_ctrl_oe <= w_ctrl_oe; r_hlda <= w_hlda;
      r_stat <= w_stat; r_ad_out <= w_ad_out; r_a_hi <= w_a_hi;
      r_rd_data <= w_rd_data;
    end
  end

  assign bus.cyc_ack  = r_ack;
  assign bus.cyc_done = r_done;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rdv;
  assign bus.bus_err  = r_berr;
  assign bus.busy     = r_busy;
  assign bus.ad_out   = r_ad_out;
  assign bus.ad_oe    = r_ad_oe;
  assign bus.a_hi     = r_a_hi;
  assign bus.ctrl_oe  = r_ctrl_oe;
  assign bus.ALE      = r_ale;
  assign bus.RDn      = r_rdn;
  assign bus.WRn      = r_wrn;
  assign bus.IOMn     = r_stat[2];
  assign bus.S1       = r_stat[1];
  assign bus.S0       = r_stat[0];
  assign bus.hlda     = r_hlda;
  assign bus.t_state  = r_state;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl with MAX_WAIT=3; expected values are
// worked out by hand from the T-state sequence of each machine cycle.
module tb_bus_cycle_ctrl;

  logic phi1 = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 phi1 = ~phi1;

  bus_cycle_ctrl_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  bus_cycle_ctrl #(.ADDR_W(16), .DATA_W(8), .MAX_WAIT(3)) dut (
    .phi1  (phi1),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic req(input logic [2:0] t, input logic lng, input logic [15:0] a,
                     input logic [7:0] d);
    bus.cyc_req = 1'b1; bus.cyc_type = t; bus.cyc_long = lng;
    bus.cyc_addr = a; bus.cyc_wdata = d;
  endtask

  initial begin
    reset = 1'b1;
    bus.cyc_req = 1'b0; bus.cyc_type = 3'd0; bus.cyc_long = 1'b0;
    bus.cyc_addr = '0; bus.cyc_wdata = '0; bus.ad_in = '0;
    bus.ready = 1'b1; bus.hold = 1'b0;
    tick(); tick();
    chk("rst_tstate", 32'(bus.t_state), 32'd0);
    chk("rst_ctrl", {bus.ALE, bus.RDn, bus.WRn, bus.ad_oe, bus.ctrl_oe, bus.hlda}, 32'b011010);
    chk("rst_status", {bus.IOMn, bus.S1, bus.S0}, 32'd0);
    chk("rst_pulses", {bus.cyc_ack, bus.cyc_done, bus.rd_valid, bus.bus_err, bus.busy}, 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    reset = 1'b0;
    tick();

    // Memory read at 0x1234, no waits
    req(3'd1, 1'b0, 16'h1234, 8'h00);
    tick();
    chk("mr_ack", {bus.cyc_ack, 4'(bus.t_state)}, {1'b1, 4'd0});
    bus.cyc_req = 1'b0;
    tick();
    chk("mr_t1", {4'(bus.t_state), bus.ALE, bus.ad_oe, bus.busy}, {4'd1, 3'b111});
    chk("mr_t1_addr", {bus.a_hi, bus.ad_out}, 32'h1234);
    chk("mr_status", {bus.IOMn, bus.S1, bus.S0}, 32'b010);
    tick();
    bus.ad_in = 8'hA5;
    chk("mr_t2", {4'(bus.t_state), bus.ALE, bus.RDn, bus.ad_oe}, {4'd2, 3'b000});
    tick();
    chk("mr_t3", {4'(bus.t_state), bus.RDn, bus.cyc_done, bus.rd_valid}, {4'd4, 3'b010});
    tick();
    chk("mr_end", {4'(bus.t_state), bus.RDn, bus.rd_valid, bus.cyc_done}, {4'd0, 3'b110});
    chk("mr_rd_data", 32'(bus.rd_data), 32'hA5);
    chk("mr_idle_status", {bus.IOMn, bus.S1, bus.S0}, 32'd0);
    tick();
    chk("mr_rdv_pulse", 32'(bus.rd_valid), 32'd0);

    // IO write 0x0040 <= 0x5C with two wait states
    req(3'd4, 1'b0, 16'h0040, 8'h5C);
    tick();
    chk("iw_ack", 32'(bus.cyc_ack), 32'd1);
    bus.cyc_req = 1'b0;
    tick();
    chk("iw_t1", {4'(bus.t_state), bus.IOMn, bus.S1, bus.S0, bus.ad_out}, {4'd1, 3'b101, 8'h40});
    bus.ready = 1'b0;
    tick();
    chk("iw_t2", {4'(bus.t_state), bus.WRn, bus.ad_oe, bus.ad_out}, {4'd2, 2'b01, 8'h5C});
    tick();
    chk("iw_tw1", {4'(bus.t_state), bus.WRn}, {4'd3, 1'b0});
    tick();
    chk("iw_tw2", {4'(bus.t_state), bus.WRn, bus.ad_out}, {4'd3, 1'b0, 8'h5C});
    bus.ready = 1'b1;
    tick();
    chk("iw_t3", {4'(bus.t_state), bus.WRn, bus.cyc_done, bus.bus_err}, {4'd4, 3'b010});
    tick();
    chk("iw_end", {4'(bus.t_state), bus.WRn, bus.ad_oe, bus.cyc_done}, {4'd0, 3'b100});

    // Long opfetch with a memory write request held throughout
    req(3'd0, 1'b1, 16'h0100, 8'h00);
    tick();
    chk("of_ack", 32'(bus.cyc_ack), 32'd1);
    req(3'd2, 1'b0, 16'h2000, 8'h77);
    tick();
    chk("of_t1", {4'(bus.t_state), bus.IOMn, bus.S1, bus.S0, bus.cyc_ack}, {4'd1, 3'b011, 1'b0});
    tick();
    bus.ad_in = 8'h3E;
    chk("of_t2", {4'(bus.t_state), bus.RDn}, {4'd2, 1'b0});
    tick();
    chk("of_t3", {4'(bus.t_state), bus.cyc_done, bus.cyc_ack}, {4'd4, 2'b00});
    tick();
    chk("of_t4", {4'(bus.t_state), bus.RDn, bus.rd_valid, bus.cyc_ack, bus.cyc_done},
        {4'd5, 4'b1100});
    chk("of_rd_data", 32'(bus.rd_data), 32'h3E);
    tick();
    chk("of_t5", {4'(bus.t_state), bus.cyc_ack, bus.rd_valid}, {4'd6, 2'b00});
    tick();
    chk("of_t6_ack", {4'(bus.t_state), bus.cyc_ack, bus.cyc_done}, {4'd7, 2'b11});
    bus.cyc_req = 1'b0;
    tick();
    chk("mw_t1", {4'(bus.t_state), bus.IOMn, bus.S1, bus.S0, bus.a_hi, bus.ad_out},
        {4'd1, 3'b001, 8'h20, 8'h00});
    tick();
    chk("mw_t2", {4'(bus.t_state), bus.WRn, bus.ad_out}, {4'd2, 1'b0, 8'h77});
    tick();
    chk("mw_t3", {4'(bus.t_state), bus.cyc_done}, {4'd4, 1'b1});
    tick();
    chk("mw_end", 32'(bus.t_state), 32'd0);

    // Hold raised during T2 of an IO read
    req(3'd3, 1'b0, 16'h0055, 8'h00);
    tick();
    bus.cyc_req = 1'b0;
    tick();
    chk("hd_t1_status", {bus.IOMn, bus.S1, bus.S0}, 32'b110);
    tick();
    bus.hold = 1'b1;
    req(3'd1, 1'b0, 16'h0ABC, 8'h00);
    tick();
    bus.ad_in = 8'h99;
    chk("hd_t3", {4'(bus.t_state), bus.cyc_done, bus.cyc_ack, bus.hlda}, {4'd4, 3'b100});
    tick();
    chk("hd_thold", {4'(bus.t_state), bus.hlda, bus.ctrl_oe, bus.ad_oe, bus.ALE, bus.cyc_ack},
        {4'd8, 5'b10000});
    chk("hd_rdv", {bus.rd_valid, bus.rd_data, bus.busy}, {1'b1, 8'h99, 1'b0});
    tick();
    chk("hd_stay", {4'(bus.t_state), bus.hlda, bus.cyc_ack}, {4'd8, 2'b10});
    bus.hold = 1'b0;
    tick();
    chk("hd_release", {4'(bus.t_state), bus.hlda, bus.ctrl_oe, bus.cyc_ack}, {4'd0, 3'b010});
    tick();
    chk("hd_late_ack", {4'(bus.t_state), bus.cyc_ack}, {4'd0, 1'b1});
    bus.cyc_req = 1'b0;
    tick();
    chk("hd_late_t1", {4'(bus.t_state), bus.a_hi, bus.ad_out}, {4'd1, 8'h0A, 8'hBC});
    tick(); tick(); tick();
    chk("hd_done_idle", 32'(bus.t_state), 32'd0);

    // Wait timeout with ready stuck low
    req(3'd1, 1'b0, 16'h0300, 8'h00);
    tick();
    bus.cyc_req = 1'b0;
    tick();
    bus.ready = 1'b0;
    tick();
    chk("to_t2", 32'(bus.t_state), 32'd2);
    tick();
    chk("to_tw1", 32'(bus.t_state), 32'd3);
    tick();
    chk("to_tw2", 32'(bus.t_state), 32'd3);
    tick();
    chk("to_tw3", {4'(bus.t_state), bus.bus_err}, {4'd3, 1'b0});
    tick();
    chk("to_t3", {4'(bus.t_state), bus.bus_err, bus.cyc_done, bus.RDn}, {4'd4, 3'b110});
    tick();
    chk("to_end", {4'(bus.t_state), bus.bus_err, bus.rd_valid}, {4'd0, 2'b01});
    bus.ready = 1'b1;

    // Reset during a wait state, then an illegal request type
    req(3'd1, 1'b0, 16'h0400, 8'h00);
    tick();
    bus.cyc_req = 1'b0;
    tick();
    bus.ready = 1'b0;
    tick(); tick();
    chk("rw_tw", {4'(bus.t_state), bus.RDn}, {4'd3, 1'b0});
    reset = 1'b1;
    tick();
    chk("rw_reset", {4'(bus.t_state), bus.RDn, bus.rd_valid, bus.cyc_done, bus.busy},
        {4'd0, 4'b1000});
    reset = 1'b0;
    bus.ready = 1'b1;
    tick();
    chk("rw_after", {4'(bus.t_state), bus.rd_valid}, {4'd0, 1'b0});
    req(3'b110, 1'b0, 16'h0500, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ill_no_ack", {4'(bus.t_state), bus.cyc_ack}, {4'd0, 1'b0});
    end
    bus.cyc_req = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
